// File: rtl/boot_uart_ctrl.sv
// boot_uart_ctrl: bootloader command sequencer between a byte UART and the SoC memories.
// Assembles little-endian words from RX bytes and decodes a {rw, addr[14:0], ndata[15:0]}
// header. Write commands stream payload words into IMEM; read commands serialise DMEM
// words to TX. cpu_hold keeps the core off the memories while a command is active.
// Optional feature macro: BOOT_ACK_EN -- after a write command, send back the 32-bit
// wrapping sum of its payload words, LSB first.
module boot_uart_ctrl #(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned IMEM_AW        = 10,
  parameter int unsigned DMEM_AW        = 10,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               dmem_re,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic [31:0]        dmem_rdata,
  output logic               cpu_hold,
  output logic               timeout_err
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HDR, S_WR, S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_ACK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;        // bytes 0..2 of the word being assembled
  logic [14:0]       cur_addr_q, cur_addr_d;
  logic [15:0]       rem_q, rem_d;          // words still to transfer
  logic [31:0]       shift_q, shift_d;      // outgoing TX word, byte 0 in [7:0]
  logic [1:0]        tx_cnt_q, tx_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef BOOT_ACK_EN
  logic [31:0]       sum_q, sum_d;
`endif

  logic        rx_phase;
  logic        rx_take;
  logic        word_done;
  logic        tx_fire;
  logic [31:0] full_word;

  // Byte intake happens only in the header and write phases; other RX bytes are dropped.
  assign rx_phase  = (state_q == S_HDR) || (state_q == S_WR);
  assign rx_take   = rx_valid && rx_phase;
  assign word_done = rx_take && (byte_cnt_q == 2'd3);
  assign full_word = {rx_data, word_q};
  assign tx_valid  = (state_q == S_RD_SEND) || (state_q == S_ACK);
  assign tx_fire   = tx_valid && tx_ready;
  assign tx_data   = shift_q[7:0];

  // The IMEM write fires in the very cycle the 4th byte strobes, so it is decoded from
  // the live RX byte rather than registered.
  assign imem_we    = (state_q == S_WR) && word_done;
  assign imem_addr  = cur_addr_q[IMEM_AW-1:0];
  assign imem_wdata = imem_we ? full_word : 32'h0;

  assign dmem_re     = (state_q == S_RD_REQ);
  assign dmem_addr   = cur_addr_q[DMEM_AW-1:0];
  assign cpu_hold    = cpu_hold_q;
  assign timeout_err = timeout_q;

  // Next-state logic: word assembly, command sequencing, TX serialisation and timeout.
  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    tx_cnt_d   = tx_cnt_q;
    to_cnt_d   = to_cnt_q;
    timeout_d  = 1'b0;
`ifdef BOOT_ACK_EN
    sum_d      = sum_q;
`endif

    if (rx_take) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = rx_data;
        2'd1:    word_d[15:8]  = rx_data;
        2'd2:    word_d[23:16] = rx_data;
        default: ;
      endcase
    end

    case (state_q)
      S_HDR: begin
        if (word_done && (full_word[15:0] != 16'h0)) begin
          rem_d      = full_word[15:0];
          cur_addr_d = full_word[30:16];
          state_d    = full_word[31] ? S_WR : S_RD_REQ;
`ifdef BOOT_ACK_EN
          sum_d      = 32'h0;
`endif
        end
      end
      S_WR: begin
        if (word_done) begin
          cur_addr_d = cur_addr_q + 15'd1;
          rem_d      = rem_q - 16'd1;
`ifdef BOOT_ACK_EN
          sum_d      = sum_q + full_word;
          if (rem_q == 16'd1) begin
            shift_d  = sum_q + full_word;
            tx_cnt_d = 2'd0;
            state_d  = S_ACK;
          end
`else
          if (rem_q == 16'd1) state_d = S_HDR;
`endif
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        shift_d  = dmem_rdata;
        tx_cnt_d = 2'd0;
        state_d  = S_RD_SEND;
      end
      S_RD_SEND: begin
        if (tx_fire) begin
          shift_d  = {8'h00, shift_q[31:8]};
          tx_cnt_d = tx_cnt_q + 2'd1;
          if (tx_cnt_q == 2'd3) begin
            cur_addr_d = cur_addr_q + 15'd1;
            rem_d      = rem_q - 16'd1;
            state_d    = (rem_q == 16'd1) ? S_HDR : S_RD_REQ;
          end
        end
      end
      S_ACK: begin
        if (tx_fire) begin
          shift_d  = {8'h00, shift_q[31:8]};
          tx_cnt_d = tx_cnt_q + 2'd1;
          if (tx_cnt_q == 2'd3) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    // Inter-byte timeout only runs while a word is partially assembled.
    if (rx_valid) begin
      to_cnt_d = '0;
    end else if (rx_phase && (byte_cnt_q != 2'd0)) begin
      if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        byte_cnt_d = 2'd0;
        word_d     = 24'h0;
        rem_d      = 16'h0;
        timeout_d  = 1'b1;
        state_d    = S_HDR;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else begin
      to_cnt_d = '0;
    end

    cpu_hold_d = (state_d != S_HDR) || (byte_cnt_d != 2'd0);
  end

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HDR;
      byte_cnt_q <= 2'd0;
      word_q     <= 24'h0;
      cur_addr_q <= 15'h0;
      rem_q      <= 16'h0;
      shift_q    <= 32'h0;
      tx_cnt_q   <= 2'd0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
`ifdef BOOT_ACK_EN
      sum_q      <= 32'h0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      tx_cnt_q   <= tx_cnt_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef BOOT_ACK_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule
